// File: rtl/ex_stage.sv
// Execute stage of a five-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump resolution and the EX/MEM pipeline register.
module ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [6:0]  id_opcode,
    input  logic [2:0]  id_funct3,
    input  logic        id_funct7b5,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs1_val,
    input  logic [31:0] id_rs2_val,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_value,
    output logic        takebranch,
    output logic [31:0] target,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_result,
    output logic [31:0] ex_store_data
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] aluB;
    logic [4:0]  shamt;
    logic [31:0] aluOut;
    logic [31:0] result;
    logic        regWrite;
    logic        branchCond;
    logic [31:0] regImmSum;
    logic [31:0] pcImmSum;
    logic [31:0] pcPlus4;

    // The MEM producer is younger than the WB producer, so it is checked last and wins.
    always_comb begin
        opA = id_rs1_val;
        if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs1))
            opA = wb_value;
        if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == id_rs1))
            opA = mem_result;

        opB = id_rs2_val;
        if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs2))
            opB = wb_value;
        if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == id_rs2))
            opB = mem_result;
    end

    assign regImmSum = opA + id_imm;
    assign pcImmSum  = id_pc + id_imm;
    assign pcPlus4   = id_pc + 32'd4;

    // Bit 30 only selects SUB for register-register adds; immediate adds ignore it.
    always_comb begin
        aluB   = (id_opcode == OPC_OP) ? opB : id_imm;
        shamt  = aluB[4:0];
        aluOut = 32'd0;
        case (id_funct3)
            3'b000: begin
                if ((id_opcode == OPC_OP) && id_funct7b5)
                    aluOut = opA - aluB;
                else
                    aluOut = opA + aluB;
            end
            3'b001: aluOut = opA << shamt;
            3'b010: aluOut = {31'd0, $signed(opA) < $signed(aluB)};
            3'b011: aluOut = {31'd0, opA < aluB};
            3'b100: aluOut = opA ^ aluB;
            3'b101: begin
                if (id_funct7b5)
                    aluOut = $signed(opA) >>> shamt;
                else
                    aluOut = opA >> shamt;
            end
            3'b110: aluOut = opA | aluB;
            3'b111: aluOut = opA & aluB;
            default: aluOut = 32'd0;
        endcase
    end

    always_comb begin
        result   = 32'd0;
        regWrite = 1'b0;
        case (id_opcode)
            OPC_OP, OPC_OPIMM: begin
                result   = aluOut;
                regWrite = 1'b1;
            end
            OPC_LUI: begin
                result   = id_imm;
                regWrite = 1'b1;
            end
            OPC_AUIPC: begin
                result   = pcImmSum;
                regWrite = 1'b1;
            end
            OPC_LOAD: begin
                result   = regImmSum;
                regWrite = 1'b1;
            end
            OPC_STORE: result = regImmSum;
            OPC_JAL, OPC_JALR: begin
                result   = pcPlus4;
                regWrite = 1'b1;
            end
            default: begin
                result   = 32'd0;
                regWrite = 1'b0;
            end
        endcase
    end

    always_comb begin
        branchCond = 1'b0;
        case (id_funct3)
            3'b000: branchCond = (opA == opB);
            3'b001: branchCond = (opA != opB);
            3'b100: branchCond = ($signed(opA) < $signed(opB));
            3'b101: branchCond = ($signed(opA) >= $signed(opB));
            3'b110: branchCond = (opA < opB);
            3'b111: branchCond = (opA >= opB);
            default: branchCond = 1'b0;
        endcase
    end

    // Redirect is resolved here in the same cycle; target reads zero when not taken.
    always_comb begin
        takebranch = 1'b0;
        target     = 32'd0;
        if (id_valid) begin
            case (id_opcode)
                OPC_JAL: begin
                    takebranch = 1'b1;
                    target     = pcImmSum;
                end
                OPC_JALR: begin
                    takebranch = 1'b1;
                    target     = {regImmSum[31:1], 1'b0};
                end
                OPC_BRANCH: begin
                    takebranch = branchCond;
                    target     = branchCond ? pcImmSum : 32'd0;
                end
                default: begin
                    takebranch = 1'b0;
                    target     = 32'd0;
                end
            endcase
        end
    end

    // EX/MEM register: holds under stall, loads a zeroed bubble when the slot is empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_valid      <= 1'b0;
            ex_regwrite   <= 1'b0;
            ex_opcode     <= 7'd0;
            ex_funct3     <= 3'd0;
            ex_rd         <= 5'd0;
            ex_result     <= 32'd0;
            ex_store_data <= 32'd0;
        end else if (!stall) begin
            if (id_valid) begin
                ex_valid      <= 1'b1;
                ex_regwrite   <= regWrite;
                ex_opcode     <= id_opcode;
                ex_funct3     <= id_funct3;
                ex_rd         <= id_rd;
                ex_result     <= result;
                ex_store_data <= opB;
            end else begin
                ex_valid      <= 1'b0;
                ex_regwrite   <= 1'b0;
                ex_opcode     <= 7'd0;
                ex_funct3     <= 3'd0;
                ex_rd         <= 5'd0;
                ex_result     <= 32'd0;
                ex_store_data <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, stall/reset
// sequences, then randomized traffic against an arithmetic reference model.
module tb_ex_stage;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    typedef struct {
        logic        valid;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1Val, rs2Val, imm, pc;
        logic        memWe;
        logic [4:0]  memRd;
        logic [31:0] memRes;
        logic        wbWe;
        logic [4:0]  wbRd;
        logic [31:0] wbVal;
    } stim_t;

    typedef struct {
        logic        take;
        logic [31:0] target;
        logic        regwrite;
        logic [31:0] result;
        logic [31:0] storeData;
    } exp_t;

    typedef struct {
        logic        valid;
        logic        regwrite;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] storeData;
    } regs_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        idValid;
    logic [6:0]  idOpcode;
    logic [2:0]  idFunct3;
    logic        idFunct7b5;
    logic [4:0]  idRs1, idRs2, idRd;
    logic [31:0] idRs1Val, idRs2Val, idImm, idPc;
    logic        memRegwrite;
    logic [4:0]  memRd;
    logic [31:0] memResult;
    logic        wbRegwrite;
    logic [4:0]  wbRd;
    logic [31:0] wbValue;
    logic        takebranch;
    logic [31:0] target;
    logic        exValid, exRegwrite;
    logic [6:0]  exOpcode;
    logic [2:0]  exFunct3;
    logic [4:0]  exRd;
    logic [31:0] exResult, exStoreData;

    int    vectors = 0;
    int    miscompares = 0;
    vec_t  tbl[$];
    stim_t tmp;
    regs_t held;
    regs_t zeroRegs;
    exp_t  e;

    ex_stage dut (
        .clock(clock), .reset(reset), .stall(stall),
        .id_valid(idValid), .id_opcode(idOpcode), .id_funct3(idFunct3),
        .id_funct7b5(idFunct7b5), .id_rs1(idRs1), .id_rs2(idRs2), .id_rd(idRd),
        .id_rs1_val(idRs1Val), .id_rs2_val(idRs2Val), .id_imm(idImm), .id_pc(idPc),
        .mem_regwrite(memRegwrite), .mem_rd(memRd), .mem_result(memResult),
        .wb_regwrite(wbRegwrite), .wb_rd(wbRd), .wb_value(wbValue),
        .takebranch(takebranch), .target(target),
        .ex_valid(exValid), .ex_regwrite(exRegwrite), .ex_opcode(exOpcode),
        .ex_funct3(exFunct3), .ex_rd(exRd), .ex_result(exResult),
        .ex_store_data(exStoreData)
    );

    always #5 clock = ~clock;

    function automatic stim_t mkStim(logic [6:0] op, logic [2:0] f3, logic f7,
                                     logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                     logic [31:0] v1, logic [31:0] v2,
                                     logic [31:0] imm, logic [31:0] pc);
        stim_t s;
        s = '{default: '0};
        s.valid = 1'b1; s.opcode = op; s.funct3 = f3; s.f7 = f7;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        s.rs1Val = v1; s.rs2Val = v2; s.imm = imm; s.pc = pc;
        return s;
    endfunction

    function automatic logic [31:0] fwd(stim_t s, logic [4:0] r, logic [31:0] v);
        if (s.memWe && s.memRd != 0 && s.memRd == r) return s.memRes;
        if (s.wbWe && s.wbRd != 0 && s.wbRd == r) return s.wbVal;
        return v;
    endfunction

    // Reference model built straight from the instruction semantics.
    function automatic exp_t model(stim_t s);
        exp_t        x;
        logic [31:0] a, b, op2;
        int          sh;
        x = '{default: '0};
        a = fwd(s, s.rs1, s.rs1Val);
        b = fwd(s, s.rs2, s.rs2Val);
        x.storeData = b;
        case (s.opcode)
            OP, OPIMM: begin
                x.regwrite = 1'b1;
                op2 = (s.opcode == OP) ? b : s.imm;
                sh = int'(op2 % 32);
                case (s.funct3)
                    3'd0: begin
                        if (s.opcode == OP && s.f7) x.result = a - op2;
                        else x.result = a + op2;
                    end
                    3'd1: x.result = a << sh;
                    3'd2: x.result = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
                    3'd3: x.result = (a < op2) ? 32'd1 : 32'd0;
                    3'd4: x.result = a ^ op2;
                    3'd5: begin
                        if (s.f7) x.result = $signed(a) >>> sh;
                        else x.result = a >> sh;
                    end
                    3'd6: x.result = a | op2;
                    default: x.result = a & op2;
                endcase
            end
            LUI:   begin x.regwrite = 1'b1; x.result = s.imm; end
            AUIPC: begin x.regwrite = 1'b1; x.result = s.pc + s.imm; end
            LOAD:  begin x.regwrite = 1'b1; x.result = a + s.imm; end
            STORE: x.result = a + s.imm;
            JAL: begin
                x.regwrite = 1'b1; x.result = s.pc + 4;
                x.take = 1'b1; x.target = s.pc + s.imm;
            end
            JALR: begin
                x.regwrite = 1'b1; x.result = s.pc + 4;
                x.take = 1'b1; x.target = (a + s.imm) & ~32'd1;
            end
            BRANCH: begin
                case (s.funct3)
                    3'd0: x.take = (a == b);
                    3'd1: x.take = (a != b);
                    3'd4: x.take = ($signed(a) < $signed(b));
                    3'd5: x.take = ($signed(a) >= $signed(b));
                    3'd6: x.take = (a < b);
                    3'd7: x.take = (a >= b);
                    default: x.take = 1'b0;
                endcase
                x.target = s.pc + s.imm;
            end
            default: ;
        endcase
        if (!s.valid) x.take = 1'b0;
        if (!x.take) x.target = 32'd0;
        return x;
    endfunction

    function automatic regs_t toRegs(stim_t s, exp_t x);
        regs_t r;
        r = '{default: '0};
        if (s.valid) begin
            r.valid = 1'b1; r.regwrite = x.regwrite; r.opcode = s.opcode;
            r.funct3 = s.funct3; r.rd = s.rd; r.result = x.result;
            r.storeData = x.storeData;
        end
        return r;
    endfunction

    function automatic logic [31:0] randVal();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) r = 32'(r % 40);
        return r;
    endfunction

    function automatic stim_t randStim();
        stim_t       s;
        logic [6:0]  ops [10];
        logic [31:0] r;
        ops = '{OP, OPIMM, LUI, AUIPC, LOAD, STORE, JAL, JALR, BRANCH, 7'b1111111};
        s.valid  = ($urandom_range(0, 9) != 0);
        s.opcode = ops[$urandom_range(0, 9)];
        s.funct3 = 3'($urandom_range(0, 7));
        s.f7     = 1'($urandom_range(0, 1));
        s.rs1    = 5'($urandom_range(0, 3));
        s.rs2    = 5'($urandom_range(0, 3));
        s.rd     = 5'($urandom_range(0, 31));
        s.rs1Val = randVal();
        s.rs2Val = ($urandom_range(0, 3) == 0) ? s.rs1Val : randVal();
        r = $urandom;
        s.imm    = {{20{r[11]}}, r[11:0]};
        r = $urandom;
        s.pc     = {r[31:2], 2'b00};
        s.memWe  = 1'($urandom_range(0, 1));
        s.memRd  = 5'($urandom_range(0, 3));
        s.memRes = randVal();
        s.wbWe   = 1'($urandom_range(0, 1));
        s.wbRd   = 5'($urandom_range(0, 3));
        s.wbVal  = randVal();
        return s;
    endfunction

    task automatic addVec(input stim_t s, input logic take, input logic [31:0] tgt,
                          input logic rw, input logic [31:0] res, input logic [31:0] sd);
        vec_t v;
        v.s = s;
        v.e.take = take; v.e.target = tgt; v.e.regwrite = rw;
        v.e.result = res; v.e.storeData = sd;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input stim_t s);
        idValid = s.valid; idOpcode = s.opcode; idFunct3 = s.funct3;
        idFunct7b5 = s.f7; idRs1 = s.rs1; idRs2 = s.rs2; idRd = s.rd;
        idRs1Val = s.rs1Val; idRs2Val = s.rs2Val; idImm = s.imm; idPc = s.pc;
        memRegwrite = s.memWe; memRd = s.memRd; memResult = s.memRes;
        wbRegwrite = s.wbWe; wbRd = s.wbRd; wbValue = s.wbVal;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkComb(input string tag, input exp_t x);
        checkOutput({tag, ".takebranch"}, 32'(takebranch), 32'(x.take));
        checkOutput({tag, ".target"}, target, x.target);
    endtask

    task automatic checkRegs(input string tag, input regs_t r);
        checkOutput({tag, ".ex_valid"}, 32'(exValid), 32'(r.valid));
        checkOutput({tag, ".ex_regwrite"}, 32'(exRegwrite), 32'(r.regwrite));
        checkOutput({tag, ".ex_opcode"}, 32'(exOpcode), 32'(r.opcode));
        checkOutput({tag, ".ex_funct3"}, 32'(exFunct3), 32'(r.funct3));
        checkOutput({tag, ".ex_rd"}, 32'(exRd), 32'(r.rd));
        checkOutput({tag, ".ex_result"}, exResult, r.result);
        checkOutput({tag, ".ex_store_data"}, exStoreData, r.storeData);
    endtask

    initial begin
        zeroRegs = '{default: '0};

        // Hand-computed directed vectors.
        addVec(mkStim(OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0),
               1'b0, 32'd0, 1'b1, 32'd12, 32'd7);
        tmp = mkStim(OPIMM, 3'd0, 1'b0, 5'd4, 5'd0, 5'd6, 32'd9, 32'd0, 32'd0, 32'd0);
        tmp.memWe = 1'b1; tmp.memRd = 5'd4; tmp.memRes = 32'd100;
        tmp.wbWe = 1'b1; tmp.wbRd = 5'd4; tmp.wbVal = 32'd200;
        addVec(tmp, 1'b0, 32'd0, 1'b1, 32'd100, 32'd0);
        tmp.memRd = 5'd0;
        addVec(tmp, 1'b0, 32'd0, 1'b1, 32'd200, 32'd0);
        addVec(mkStim(BRANCH, 3'd4, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'd1,
                      32'hFFFFFFF8, 32'h40), 1'b1, 32'h38, 1'b0, 32'd0, 32'd1);
        addVec(mkStim(BRANCH, 3'd6, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'd1,
                      32'hFFFFFFF8, 32'h40), 1'b0, 32'd0, 1'b0, 32'd0, 32'd1);
        addVec(mkStim(JALR, 3'd0, 1'b0, 5'd5, 5'd0, 5'd1, 32'h1001, 32'd0, 32'd2, 32'h20),
               1'b1, 32'h1002, 1'b1, 32'h24, 32'd0);
        addVec(mkStim(OP, 3'd5, 1'b1, 5'd1, 5'd2, 5'd7, 32'h80000000, 32'd33, 32'd0, 32'd0),
               1'b0, 32'd0, 1'b1, 32'hC0000000, 32'd33);
        addVec(mkStim(OP, 3'd5, 1'b0, 5'd1, 5'd2, 5'd7, 32'h80000000, 32'd33, 32'd0, 32'd0),
               1'b0, 32'd0, 1'b1, 32'h40000000, 32'd33);
        addVec(mkStim(OP, 3'd0, 1'b1, 5'd1, 5'd2, 5'd8, 32'd5, 32'd7, 32'd0, 32'd0),
               1'b0, 32'd0, 1'b1, 32'hFFFFFFFE, 32'd7);
        addVec(mkStim(OP, 3'd2, 1'b0, 5'd1, 5'd2, 5'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0),
               1'b0, 32'd0, 1'b1, 32'd1, 32'd1);
        addVec(mkStim(OP, 3'd3, 1'b0, 5'd1, 5'd2, 5'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0),
               1'b0, 32'd0, 1'b1, 32'd0, 32'd1);
        addVec(mkStim(OPIMM, 3'd5, 1'b1, 5'd1, 5'd0, 5'd10, 32'h80000000, 32'd0, 32'h404, 32'd0),
               1'b0, 32'd0, 1'b1, 32'hF8000000, 32'd0);
        addVec(mkStim(OPIMM, 3'd0, 1'b1, 5'd1, 5'd0, 5'd11, 32'h1000, 32'd0, 32'hFFFFFC00, 32'd0),
               1'b0, 32'd0, 1'b1, 32'hC00, 32'd0);
        addVec(mkStim(JAL, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h20, 32'h100),
               1'b1, 32'h120, 1'b1, 32'h104, 32'd0);
        addVec(mkStim(LUI, 3'd0, 1'b0, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'h12345000, 32'd0),
               1'b0, 32'd0, 1'b1, 32'h12345000, 32'd0);
        addVec(mkStim(AUIPC, 3'd0, 1'b0, 5'd0, 5'd0, 5'd13, 32'd0, 32'd0, 32'h2000, 32'h1000),
               1'b0, 32'd0, 1'b1, 32'h3000, 32'd0);
        addVec(mkStim(STORE, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 32'h100, 32'hDEAD, 32'd8, 32'd0),
               1'b0, 32'd0, 1'b0, 32'h108, 32'hDEAD);
        addVec(mkStim(BRANCH, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd3, 32'h10, 32'h80),
               1'b0, 32'd0, 1'b0, 32'd0, 32'd3);
        tmp = mkStim(BRANCH, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 32'h10, 32'h80);
        tmp.wbWe = 1'b1; tmp.wbRd = 5'd2; tmp.wbVal = 32'd6;
        addVec(tmp, 1'b1, 32'h90, 1'b0, 32'd0, 32'd6);
        addVec(mkStim(BRANCH, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 32'd1, 32'hFFFFFFFF, 32'h10, 32'h80),
               1'b0, 32'd0, 1'b0, 32'd0, 32'hFFFFFFFF);
        addVec(mkStim(7'b1111111, 3'd0, 1'b0, 5'd1, 5'd2, 5'd14, 32'd5, 32'd7, 32'd0, 32'd0),
               1'b0, 32'd0, 1'b0, 32'd0, 32'd7);
        tmp = mkStim(JAL, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h20, 32'h100);
        tmp.valid = 1'b0;
        addVec(tmp, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

        // Reset state, with the redirect path still live while reset is held.
        reset = 1'b0;
        stall = 1'b0;
        applyStimulus(mkStim(JAL, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h8, 32'h10));
        repeat (2) @(posedge clock);
        #1;
        checkRegs("reset", zeroRegs);
        checkOutput("reset.takebranch", 32'(takebranch), 32'd1);
        checkOutput("reset.target", target, 32'h18);

        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clock);
            applyStimulus(tbl[i].s);
            #1;
            checkComb(tag, tbl[i].e);
            @(posedge clock);
            #1;
            checkRegs(tag, toRegs(tbl[i].s, tbl[i].e));
        end

        // Capture ADD, then stall three cycles while the inputs keep changing.
        @(negedge clock);
        applyStimulus(tbl[0].s);
        @(posedge clock);
        #1;
        held = toRegs(tbl[0].s, tbl[0].e);
        checkRegs("stallCapture", held);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            applyStimulus(tbl[i + 3].s);
            #1;
            checkComb($sformatf("stall%0d", i), tbl[i + 3].e);
            @(posedge clock);
            #1;
            checkRegs($sformatf("stall%0d", i), held);
        end
        #2;
        reset = 1'b0;
        #1;
        checkRegs("resetMidStall", zeroRegs);
        @(posedge clock);
        #1;
        checkRegs("resetHeld", zeroRegs);

        // First capture after reset release.
        @(negedge clock);
        reset = 1'b1;
        stall = 1'b0;
        applyStimulus(tbl[6].s);
        @(posedge clock);
        #1;
        checkRegs("firstCapture", toRegs(tbl[6].s, tbl[6].e));
        held = toRegs(tbl[6].s, tbl[6].e);

        // Randomized traffic with occasional stalls.
        for (int n = 0; n < 400; n++) begin
            stim_t s;
            s = randStim();
            e = model(s);
            @(negedge clock);
            stall = ($urandom_range(0, 4) == 0);
            applyStimulus(s);
            #1;
            checkComb($sformatf("rand%0d", n), e);
            @(posedge clock);
            if (!stall) held = toRegs(s, e);
            #1;
            checkRegs($sformatf("rand%0d", n), held);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
